// File: rtl/hit_resolver.sv
// hit_resolver: arbitrates attacks between the two players.
// Detects active-frame overlaps, issues one-cycle hit flags one edge after a
// hit is registered, applies damage unless the victim is blocking, and keeps
// health, game-over and winner status. Every output is a flop.
module hit_resolver #(
  parameter int HEALTH_MAX = 3,
  parameter int DMG_BASIC  = 1,
  parameter int DMG_DIR    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] p1_state,
  input  logic [9:0] p1_basic_x1,
  input  logic [9:0] p1_basic_x2,
  input  logic [9:0] p1_basic_y1,
  input  logic [9:0] p1_basic_y2,
  input  logic [9:0] p1_dir_x1,
  input  logic [9:0] p1_dir_x2,
  input  logic [9:0] p1_dir_y1,
  input  logic [9:0] p1_dir_y2,
  input  logic [9:0] p1_hurt_x1,
  input  logic [9:0] p1_hurt_x2,
  input  logic [9:0] p1_hurt_y1,
  input  logic [9:0] p1_hurt_y2,
  input  logic [3:0] p2_state,
  input  logic [9:0] p2_basic_x1,
  input  logic [9:0] p2_basic_x2,
  input  logic [9:0] p2_basic_y1,
  input  logic [9:0] p2_basic_y2,
  input  logic [9:0] p2_dir_x1,
  input  logic [9:0] p2_dir_x2,
  input  logic [9:0] p2_dir_y1,
  input  logic [9:0] p2_dir_y2,
  input  logic [9:0] p2_hurt_x1,
  input  logic [9:0] p2_hurt_x2,
  input  logic [9:0] p2_hurt_y1,
  input  logic [9:0] p2_hurt_y2,
  output logic [1:0] p1_hitFlag,
  output logic [1:0] p2_hitFlag,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [2:0] HMAX  = 3'(HEALTH_MAX);
  localparam logic [2:0] DMG_B = 3'(DMG_BASIC);
  localparam logic [2:0] DMG_D = 3'(DMG_DIR);

  localparam logic [3:0] ST_BACK      = 4'd2;
  localparam logic [3:0] ST_BASIC_ACT = 4'd4;
  localparam logic [3:0] ST_DIR_ACT   = 4'd7;
  localparam logic [3:0] ST_HITSTUN   = 4'd9;
  localparam logic [3:0] ST_BLOCKSTUN = 4'd10;

  // Inclusive rectangle intersection; touching edges count as contact.
  function automatic logic overlap(
    input logic [9:0] ax1, ax2, ay1, ay2,
    input logic [9:0] bx1, bx2, by1, by2
  );
    return (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
  endfunction

  // Health never wraps below zero.
  function automatic logic [2:0] sat_sub(input logic [2:0] h, input logic [2:0] d);
    return (h <= d) ? 3'd0 : h - d;
  endfunction

  // Landed latches plus the registered hit stage (type and block sampled with it).
  logic landed1, landed2;
  logic hit1_q, hit2_q;
  logic dir1_q, dir2_q;
  logic blk1_q, blk2_q;

  logic ov1, ov2, hit1, hit2;
  logic fire1, fire2;
  logic [2:0] p1_health_nx, p2_health_nx;

  // Detect overlaps this cycle and compute the damage the pending hits will apply.
  always_comb begin
    ov1 = 1'b0;
    ov2 = 1'b0;
    if (p1_state == ST_BASIC_ACT)
      ov1 = overlap(p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2,
                    p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
    else if (p1_state == ST_DIR_ACT)
      ov1 = overlap(p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2,
                    p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
    if (p2_state == ST_BASIC_ACT)
      ov2 = overlap(p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2,
                    p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);
    else if (p2_state == ST_DIR_ACT)
      ov2 = overlap(p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2,
                    p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);

    hit1 = ov1 && !landed1 && (p2_state != ST_HITSTUN) && !game_over;
    hit2 = ov2 && !landed2 && (p1_state != ST_HITSTUN) && !game_over;

    // A hit registered just before the game ended must not land afterwards.
    fire1 = hit1_q && !game_over;
    fire2 = hit2_q && !game_over;

    p2_health_nx = p2_health;
    p1_health_nx = p1_health;
    if (fire1 && !blk1_q)
      p2_health_nx = sat_sub(p2_health, dir1_q ? DMG_D : DMG_B);
    if (fire2 && !blk2_q)
      p1_health_nx = sat_sub(p1_health, dir2_q ? DMG_D : DMG_B);
  end

  // Register hits, drive flags/health, and latch game-over and the winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      landed1    <= 1'b0;
      landed2    <= 1'b0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      dir1_q     <= 1'b0;
      dir2_q     <= 1'b0;
      blk1_q     <= 1'b0;
      blk2_q     <= 1'b0;
      p1_hitFlag <= 2'b00;
      p2_hitFlag <= 2'b00;
      p1_health  <= HMAX;
      p2_health  <= HMAX;
      game_over  <= 1'b0;
      winner     <= 2'b00;
    end else begin
      landed1 <= (p1_state == ST_BASIC_ACT || p1_state == ST_DIR_ACT) && (landed1 || hit1);
      landed2 <= (p2_state == ST_BASIC_ACT || p2_state == ST_DIR_ACT) && (landed2 || hit2);

      hit1_q <= hit1;
      hit2_q <= hit2;
      dir1_q <= (p1_state == ST_DIR_ACT);
      dir2_q <= (p2_state == ST_DIR_ACT);
      blk1_q <= (p2_state == ST_BACK) || (p2_state == ST_BLOCKSTUN);
      blk2_q <= (p1_state == ST_BACK) || (p1_state == ST_BLOCKSTUN);

      p2_hitFlag <= fire1 ? (dir1_q ? 2'b10 : 2'b01) : 2'b00;
      p1_hitFlag <= fire2 ? (dir2_q ? 2'b10 : 2'b01) : 2'b00;
      p1_health  <= p1_health_nx;
      p2_health  <= p2_health_nx;

      if (!game_over && (p1_health_nx == 3'd0 || p2_health_nx == 3'd0)) begin
        game_over <= 1'b1;
        winner    <= {p1_health_nx == 3'd0, p2_health_nx == 3'd0};
      end
    end
  end

endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver: directed checks of hit_resolver with hand-computed expectations.
module tb_hit_resolver;

  logic       clk;
  logic       rst;
  logic [3:0] p1_state, p2_state;
  logic [9:0] p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2;
  logic [9:0] p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2;
  logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
  logic [9:0] p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2;
  logic [9:0] p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2;
  logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
  logic [1:0] p1_hitFlag, p2_hitFlag;
  logic [2:0] p1_health, p2_health;
  logic       game_over;
  logic [1:0] winner;

  int checks;
  int passed;

  hit_resolver dut (
    .clk(clk), .rst(rst),
    .p1_state(p1_state),
    .p1_basic_x1(p1_basic_x1), .p1_basic_x2(p1_basic_x2),
    .p1_basic_y1(p1_basic_y1), .p1_basic_y2(p1_basic_y2),
    .p1_dir_x1(p1_dir_x1), .p1_dir_x2(p1_dir_x2),
    .p1_dir_y1(p1_dir_y1), .p1_dir_y2(p1_dir_y2),
    .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2),
    .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
    .p2_state(p2_state),
    .p2_basic_x1(p2_basic_x1), .p2_basic_x2(p2_basic_x2),
    .p2_basic_y1(p2_basic_y1), .p2_basic_y2(p2_basic_y2),
    .p2_dir_x1(p2_dir_x1), .p2_dir_x2(p2_dir_x2),
    .p2_dir_y1(p2_dir_y1), .p2_dir_y2(p2_dir_y2),
    .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2),
    .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
    .p1_hitFlag(p1_hitFlag), .p2_hitFlag(p2_hitFlag),
    .p1_health(p1_health), .p2_health(p2_health),
    .game_over(game_over), .winner(winner)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it when it disagrees.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
  endtask

  // Drive both player states right after a falling edge, then wait some falling edges.
  task automatic applyStimulus(input logic [3:0] s1, input logic [3:0] s2, input int cycles);
    p1_state = s1;
    p2_state = s2;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    p1_state = 4'd0;
    p2_state = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " p1_hitFlag"}, int'(p1_hitFlag), 0);
    checkOutput({tag, " p2_hitFlag"}, int'(p2_hitFlag), 0);
    checkOutput({tag, " p1_health"}, int'(p1_health), 3);
    checkOutput({tag, " p2_health"}, int'(p2_health), 3);
    checkOutput({tag, " game_over"}, int'(game_over), 0);
    checkOutput({tag, " winner"}, int'(winner), 0);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    p1_state = 4'd0;
    p2_state = 4'd0;
    // P1 hurt x 0..50; P2 hurt x 200..300. P1 attack boxes reach x=200 (edge
    // contact), P2 attack boxes reach back into P1's hurtbox. All y 0..100.
    p1_hurt_x1 = 10'd0;    p1_hurt_x2 = 10'd50;
    p2_hurt_x1 = 10'd200;  p2_hurt_x2 = 10'd300;
    p1_basic_x1 = 10'd150; p1_basic_x2 = 10'd200;
    p1_dir_x1 = 10'd150;   p1_dir_x2 = 10'd250;
    p2_basic_x1 = 10'd40;  p2_basic_x2 = 10'd60;
    p2_dir_x1 = 10'd30;    p2_dir_x2 = 10'd60;
    p1_hurt_y1 = 10'd0;  p1_hurt_y2 = 10'd100;
    p2_hurt_y1 = 10'd0;  p2_hurt_y2 = 10'd100;
    p1_basic_y1 = 10'd0; p1_basic_y2 = 10'd100;
    p1_dir_y1 = 10'd0;   p1_dir_y2 = 10'd100;
    p2_basic_y1 = 10'd0; p2_basic_y2 = 10'd100;
    p2_dir_y1 = 10'd0;   p2_dir_y2 = 10'd100;

    // Basic hit, one-cycle latency, single landing while held active.
    doReset();
    checkIdleOutputs("reset");
    applyStimulus(4'd4, 4'd0, 1);
    checkOutput("basic latency p2_hitFlag", int'(p2_hitFlag), 0);
    @(negedge clk);
    checkOutput("basic p2_hitFlag", int'(p2_hitFlag), 1);
    checkOutput("basic p2_health", int'(p2_health), 2);
    checkOutput("basic p1_hitFlag", int'(p1_hitFlag), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("basic hold%0d p2_hitFlag", i), int'(p2_hitFlag), 0);
      checkOutput($sformatf("basic hold%0d p2_health", i), int'(p2_health), 2);
    end

    // Blocked directional hit: flag issued, health kept.
    doReset();
    applyStimulus(4'd7, 4'd2, 2);
    checkOutput("block p2_hitFlag", int'(p2_hitFlag), 2);
    checkOutput("block p2_health", int'(p2_health), 3);
    @(negedge clk);
    checkOutput("block flag drop", int'(p2_hitFlag), 0);

    // Edge contact at x=200 lands; x2=199 misses.
    doReset();
    applyStimulus(4'd4, 4'd0, 2);
    checkOutput("edge200 p2_hitFlag", int'(p2_hitFlag), 1);
    applyStimulus(4'd0, 4'd0, 1);
    p1_basic_x2 = 10'd199;
    applyStimulus(4'd4, 4'd0, 2);
    checkOutput("edge199 p2_hitFlag", int'(p2_hitFlag), 0);
    @(negedge clk);
    checkOutput("edge199 late flag", int'(p2_hitFlag), 0);
    checkOutput("edge199 p2_health", int'(p2_health), 2);
    p1_basic_x2 = 10'd200;

    // Two directional hits bring both to 1, then a mutual basic trade draws.
    doReset();
    applyStimulus(4'd7, 4'd0, 2);
    checkOutput("trade setup p2_health", int'(p2_health), 1);
    applyStimulus(4'd0, 4'd7, 2);
    checkOutput("trade setup p1_hitFlag", int'(p1_hitFlag), 2);
    checkOutput("trade setup p1_health", int'(p1_health), 1);
    applyStimulus(4'd0, 4'd0, 1);
    applyStimulus(4'd4, 4'd4, 2);
    checkOutput("trade p1_hitFlag", int'(p1_hitFlag), 1);
    checkOutput("trade p2_hitFlag", int'(p2_hitFlag), 1);
    checkOutput("trade p1_health", int'(p1_health), 0);
    checkOutput("trade p2_health", int'(p2_health), 0);
    checkOutput("trade game_over", int'(game_over), 1);
    checkOutput("trade winner", int'(winner), 3);

    // Two directional hits from 3 saturate at 0; game over stays and blocks hits.
    doReset();
    applyStimulus(4'd7, 4'd0, 2);
    checkOutput("sticky first p2_health", int'(p2_health), 1);
    applyStimulus(4'd0, 4'd0, 1);
    applyStimulus(4'd7, 4'd0, 2);
    checkOutput("sticky second p2_hitFlag", int'(p2_hitFlag), 2);
    checkOutput("sticky p2_health", int'(p2_health), 0);
    checkOutput("sticky game_over", int'(game_over), 1);
    checkOutput("sticky winner", int'(winner), 1);
    applyStimulus(4'd0, 4'd0, 1);
    applyStimulus(4'd4, 4'd4, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("sticky after%0d p2_hitFlag", i), int'(p2_hitFlag), 0);
      checkOutput($sformatf("sticky after%0d p1_hitFlag", i), int'(p1_hitFlag), 0);
    end
    checkOutput("sticky p1_health kept", int'(p1_health), 3);
    checkOutput("sticky winner kept", int'(winner), 1);

    // Asynchronous reset with a hit pending, then a fresh hit lands.
    doReset();
    applyStimulus(4'd7, 4'd0, 2);
    applyStimulus(4'd0, 4'd0, 1);
    applyStimulus(4'd4, 4'd0, 1);
    checkOutput("midreset pre p2_health", int'(p2_health), 1);
    #2;
    rst = 1'b0;
    p1_state = 4'd0;
    #1;
    checkIdleOutputs("midreset");
    @(negedge clk);
    @(negedge clk);
    checkIdleOutputs("midreset held");
    rst = 1'b1;
    applyStimulus(4'd4, 4'd0, 2);
    checkOutput("after reset p2_hitFlag", int'(p2_hitFlag), 1);
    checkOutput("after reset p2_health", int'(p2_health), 2);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
